// File: rtl/bird_motion_ctrl.sv
// Bird motion controller: turns flap taps and frame ticks into the
// trajectory-lookup index, combines the lookup offset with the row latched at
// the last tap, and tracks the bird life cycle (IDLE / FLY / FALL / DEAD).
module bird_motion_ctrl #(
  parameter int Y_START = 240,
  parameter int Y_TOP   = 0,
  parameter int Y_FLOOR = 400,
  parameter int TAP_SAT = 127
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               frame_tick,
  input  logic               tap_btn,
  input  logic               game_start,
  input  logic               collide,
  input  logic signed [12:0] bird_go_up,
  output logic        [12:0] bird_tap_time,
  output logic        [9:0]  bird_y,
  output logic        [1:0]  bird_state,
  output logic               ground_hit
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FLY  = 2'd1,
    ST_FALL = 2'd2,
    ST_DEAD = 2'd3
  } state_t;

  localparam logic        [9:0]  Y_START_C = 10'(Y_START);
  localparam logic        [9:0]  Y_TOP_C   = 10'(Y_TOP);
  localparam logic        [9:0]  Y_FLOOR_C = 10'(Y_FLOOR);
  localparam logic signed [12:0] Y_TOP_S   = 13'(Y_TOP);
  localparam logic signed [12:0] Y_FLOOR_S = 13'(Y_FLOOR);
  localparam logic        [12:0] TAP_SAT_C = 13'(TAP_SAT);

  // Frame counter step that sticks at the saturation value.
  function automatic logic [12:0] sat_inc(input logic [12:0] t);
    logic [12:0] r;
    if (t >= TAP_SAT_C) begin
      r = TAP_SAT_C;
    end else begin
      r = t + 13'd1;
    end
    return r;
  endfunction

  state_t             state_r;
  logic        [12:0] tap_time_r;
  logic        [9:0]  y_r;
  logic        [9:0]  base_y_r;
  logic               ground_hit_r;
  logic               sync1_r;
  logic               sync2_r;
  logic               sync2_d_r;

  logic               tap_ev_s;
  logic signed [12:0] y_calc_s;
  logic        [9:0]  y_clamp_s;
  logic               floor_s;
  logic        [12:0] tap_next_s;

  // One accepted tap per rising edge of the synchronized button level.
  assign tap_ev_s = sync2_r & ~sync2_d_r;

  // Row from the latched base and lookup offset, clamped to ceiling and floor.
  always_comb begin
    y_calc_s  = $signed({3'b000, base_y_r}) - bird_go_up;
    y_clamp_s = y_calc_s[9:0];
    floor_s   = 1'b0;
    if (y_calc_s < Y_TOP_S) begin
      y_clamp_s = Y_TOP_C;
    end else if (y_calc_s >= Y_FLOOR_S) begin
      y_clamp_s = Y_FLOOR_C;
      floor_s   = 1'b1;
    end else begin
      y_clamp_s = y_calc_s[9:0];
    end
  end

  // Next frame index while airborne: a tap restarts it, else a tick advances it.
  always_comb begin
    tap_next_s = tap_time_r;
    if (tap_ev_s && (state_r == ST_FLY)) begin
      tap_next_s = 13'd1;
    end else if (frame_tick) begin
      tap_next_s = sat_inc(tap_time_r);
    end else begin
      tap_next_s = tap_time_r;
    end
  end

  // Button synchronizer, life-cycle FSM and all registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_r      <= 1'b0;
      sync2_r      <= 1'b0;
      sync2_d_r    <= 1'b0;
      state_r      <= ST_IDLE;
      tap_time_r   <= 13'd0;
      y_r          <= Y_START_C;
      base_y_r     <= Y_START_C;
      ground_hit_r <= 1'b0;
    end else begin
      sync1_r      <= tap_btn;
      sync2_r      <= sync1_r;
      sync2_d_r    <= sync2_r;
      ground_hit_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          tap_time_r <= 13'd0;
          y_r        <= Y_START_C;
          if (tap_ev_s) begin
            base_y_r   <= y_r;
            tap_time_r <= 13'd1;
            state_r    <= ST_FLY;
          end else begin
            state_r    <= ST_IDLE;
          end
        end
        ST_FLY: begin
          y_r <= y_clamp_s;
          if (floor_s) begin
            // Landing beats a same-cycle tap or collision; index stays put.
            state_r      <= ST_DEAD;
            ground_hit_r <= 1'b1;
          end else begin
            if (tap_ev_s) begin
              base_y_r <= y_r;
            end else begin
              base_y_r <= base_y_r;
            end
            tap_time_r <= tap_next_s;
            if (collide) begin
              state_r <= ST_FALL;
            end else begin
              state_r <= ST_FLY;
            end
          end
        end
        ST_FALL: begin
          y_r <= y_clamp_s;
          if (floor_s) begin
            state_r      <= ST_DEAD;
            ground_hit_r <= 1'b1;
          end else begin
            tap_time_r <= tap_next_s;
            state_r    <= ST_FALL;
          end
        end
        ST_DEAD: begin
          if (game_start) begin
            state_r    <= ST_IDLE;
            tap_time_r <= 13'd0;
            y_r        <= Y_START_C;
            base_y_r   <= Y_START_C;
          end else begin
            state_r    <= ST_DEAD;
          end
        end
        default: begin
          state_r    <= ST_IDLE;
          tap_time_r <= 13'd0;
          y_r        <= Y_START_C;
          base_y_r   <= Y_START_C;
        end
      endcase
    end
  end

  assign bird_tap_time = tap_time_r;
  assign bird_y        = y_r;
  assign bird_state    = state_r;
  assign ground_hit    = ground_hit_r;

endmodule

// File: tb/tb_bird_motion_ctrl.sv
// Directed bench for bird_motion_ctrl with a behavioural trajectory lookup.
module tb_bird_motion_ctrl;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               frame_tick, tap_btn, game_start, collide;
  logic signed [12:0] go_up;
  logic        [12:0] tap_time;
  logic        [9:0]  y;
  logic        [1:0]  state;
  logic               ground_hit;

  logic               c_tick, c_tap;
  logic signed [12:0] c_go_up;
  logic        [12:0] c_tap_time;
  logic        [9:0]  c_y;
  logic        [1:0]  c_state;
  logic               c_gh;

  // Lookup control: 0 = parabola, 1 = constant, 2 = direct override.
  logic        [1:0]  lut_mode;
  logic signed [12:0] lut_const;
  logic signed [12:0] ovr;

  int checks = 0;
  int errors = 0;
  int gh_cnt = 0;

  always #5 clk = ~clk;

  bird_motion_ctrl u_dut (
    .clk(clk), .rst_n(rst_n), .frame_tick(frame_tick), .tap_btn(tap_btn),
    .game_start(game_start), .collide(collide), .bird_go_up(go_up),
    .bird_tap_time(tap_time), .bird_y(y), .bird_state(state), .ground_hit(ground_hit)
  );

  bird_motion_ctrl #(.Y_START(20)) u_ceil (
    .clk(clk), .rst_n(rst_n), .frame_tick(c_tick), .tap_btn(c_tap),
    .game_start(1'b0), .collide(1'b0), .bird_go_up(c_go_up),
    .bird_tap_time(c_tap_time), .bird_y(c_y), .bird_state(c_state), .ground_hit(c_gh)
  );

  // Rising then falling trajectory: go_up(15) = 40, floor from 240 at t = 70.
  function automatic int curve(input int t);
    return 4 * t - (t * t) / 11;
  endfunction

  always_comb begin
    case (lut_mode)
      2'd0:    go_up = 13'(curve(int'(tap_time)));
      2'd1:    go_up = lut_const;
      default: go_up = ovr;
    endcase
  end

  assign c_go_up = 13'(curve(int'(c_tap_time)));

  typedef struct {
    logic signed [12:0] gu;
    logic               col;
    logic        [9:0]  exp_y;
    logic        [1:0]  exp_state;
    logic               exp_gh;
  } vec_t;

  vec_t vecs [9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    if (ground_hit === 1'b1) gh_cnt++;
  endtask

  task automatic tick();
    frame_tick = 1'b1;
    step();
    frame_tick = 1'b0;
    step();
  endtask

  task automatic cstep();
    step();
    chk("ceil_row_range", 32'(c_y <= 10'd20), 32'd1);
    chk("ceil_state_fly", 32'(c_state), 32'd1);
  endtask

  initial begin
    vecs[0] = '{13'sd0,     1'b0, 10'd240, 2'd1, 1'b0};
    vecs[1] = '{13'sd40,    1'b0, 10'd200, 2'd1, 1'b0};
    vecs[2] = '{13'sd240,   1'b0, 10'd0,   2'd1, 1'b0};
    vecs[3] = '{13'sd241,   1'b0, 10'd0,   2'd1, 1'b0};
    vecs[4] = '{13'sd4095,  1'b0, 10'd0,   2'd1, 1'b0};
    vecs[5] = '{-13'sd100,  1'b0, 10'd340, 2'd1, 1'b0};
    vecs[6] = '{-13'sd159,  1'b0, 10'd399, 2'd1, 1'b0};
    vecs[7] = '{-13'sd160,  1'b1, 10'd400, 2'd3, 1'b1};
    vecs[8] = '{13'sd0,     1'b0, 10'd400, 2'd3, 1'b0};

    rst_n = 1'b0; frame_tick = 1'b0; tap_btn = 1'b0; game_start = 1'b0; collide = 1'b0;
    c_tick = 1'b0; c_tap = 1'b0;
    lut_mode = 2'd0; lut_const = 13'sd0; ovr = 13'sd0;
    step(); step(); step();
    rst_n = 1'b1;
    step();
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_tap_time", 32'(tap_time), 32'd0);
    chk("rst_y", 32'(y), 32'd240);
    chk("rst_gh", 32'(ground_hit), 32'd0);

    // IDLE ignores tick, collide and restart.
    frame_tick = 1'b1; collide = 1'b1; game_start = 1'b1;
    step();
    frame_tick = 1'b0; collide = 1'b0; game_start = 1'b0;
    step();
    chk("idle_state", 32'(state), 32'd0);
    chk("idle_tap_time", 32'(tap_time), 32'd0);

    // First tap: three-edge latency.
    tap_btn = 1'b1;
    step(); step();
    chk("tap_not_early", 32'(tap_time), 32'd0);
    step();
    chk("tap_first_time", 32'(tap_time), 32'd1);
    chk("tap_first_state", 32'(state), 32'd1);
    chk("tap_first_y", 32'(y), 32'd240);
    for (int i = 0; i < 14; i++) tick();
    chk("fly15_time", 32'(tap_time), 32'd15);
    chk("fly15_y", 32'(y), 32'd200);

    // Re-tap at 30 together with a tick.
    tap_btn = 1'b0;
    for (int i = 0; i < 15; i++) tick();
    chk("fly30_y", 32'(y), 32'd201);
    tap_btn = 1'b1;
    step(); step();
    frame_tick = 1'b1;
    step();
    frame_tick = 1'b0;
    chk("retap_time", 32'(tap_time), 32'd1);
    chk("retap_row", 32'(y), 32'd201);
    step();
    chk("retap_base", 32'(y), 32'd197);
    tick(); tick();
    chk("held_no_retap", 32'(tap_time), 32'd3);
    tap_btn = 1'b0;
    for (int i = 0; i < 37; i++) tick();
    chk("fly40_time", 32'(tap_time), 32'd40);

    // Asynchronous reset mid-flight.
    rst_n = 1'b0;
    #1;
    chk("async_rst_state", 32'(state), 32'd0);
    chk("async_rst_time", 32'(tap_time), 32'd0);
    chk("async_rst_y", 32'(y), 32'd240);
    chk("async_rst_gh", 32'(ground_hit), 32'd0);
    step();
    rst_n = 1'b1;
    step();

    // Saturation with a flat lookup, then drop to the floor.
    lut_mode = 2'd1; lut_const = 13'sd0;
    tap_btn = 1'b1;
    step(); step(); step();
    tap_btn = 1'b0;
    chk("sat_fly", 32'(state), 32'd1);
    for (int i = 0; i < 130; i++) tick();
    chk("sat_time", 32'(tap_time), 32'd127);
    chk("sat_y", 32'(y), 32'd240);
    lut_const = -13'sd160;
    step();
    chk("floor_state", 32'(state), 32'd3);
    chk("floor_y", 32'(y), 32'd400);
    chk("floor_gh", 32'(ground_hit), 32'd1);
    step();
    chk("floor_gh_single", 32'(ground_hit), 32'd0);
    lut_const = 13'sd0;
    tick();
    chk("dead_y_frozen", 32'(y), 32'd400);
    chk("dead_time_frozen", 32'(tap_time), 32'd127);
    chk("dead_state_hold", 32'(state), 32'd3);

    game_start = 1'b1;
    step();
    game_start = 1'b0;
    chk("restart_state", 32'(state), 32'd0);
    chk("restart_y", 32'(y), 32'd240);
    chk("restart_time", 32'(tap_time), 32'd0);

    // Table: clamp arithmetic around a base of 240.
    lut_mode = 2'd0;
    tap_btn = 1'b1;
    step(); step(); step();
    tap_btn = 1'b0;
    lut_mode = 2'd2;
    for (int i = 0; i < 9; i++) begin
      ovr = vecs[i].gu;
      collide = vecs[i].col;
      step();
      collide = 1'b0;
      chk($sformatf("vec%0d_y", i), 32'(y), 32'(vecs[i].exp_y));
      chk($sformatf("vec%0d_state", i), 32'(state), 32'(vecs[i].exp_state));
      chk($sformatf("vec%0d_gh", i), 32'(ground_hit), 32'(vecs[i].exp_gh));
    end

    // Collision, ignored taps, fall to the floor, restart.
    lut_mode = 2'd0;
    game_start = 1'b1;
    step();
    game_start = 1'b0;
    tap_btn = 1'b1;
    step(); step(); step();
    tap_btn = 1'b0;
    for (int i = 0; i < 9; i++) tick();
    chk("pre_col_time", 32'(tap_time), 32'd10);
    chk("pre_col_y", 32'(y), 32'd209);
    collide = 1'b1;
    step();
    collide = 1'b0;
    chk("fall_state", 32'(state), 32'd2);
    tap_btn = 1'b1;
    step(); step(); step(); step();
    tap_btn = 1'b0;
    chk("fall_tap_ignored", 32'(tap_time), 32'd10);
    chk("fall_state_hold", 32'(state), 32'd2);
    gh_cnt = 0;
    for (int i = 0; i < 100; i++) begin
      if (state == 2'd3) break;
      tick();
    end
    step(); step();
    chk("fall_dead_state", 32'(state), 32'd3);
    chk("fall_dead_y", 32'(y), 32'd400);
    chk("fall_dead_time", 32'(tap_time), 32'd70);
    chk("fall_gh_count", 32'(gh_cnt), 32'd1);
    game_start = 1'b1;
    step();
    game_start = 1'b0;
    chk("restart2_state", 32'(state), 32'd0);
    chk("restart2_y", 32'(y), 32'd240);
    chk("restart2_time", 32'(tap_time), 32'd0);

    // Ceiling clamp with a low start row and rapid taps.
    c_tap = 1'b1;
    step(); step(); step();
    chk("ceil_start_state", 32'(c_state), 32'd1);
    chk("ceil_start_y", 32'(c_y), 32'd20);
    for (int i = 0; i < 12; i++) begin
      c_tap = 1'b0;
      c_tick = 1'b1;
      cstep();
      c_tick = 1'b0;
      cstep();
      c_tap = 1'b1;
      cstep(); cstep(); cstep();
    end
    c_tap = 1'b0;
    chk("ceil_final_y", 32'(c_y), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bird_motion_ctrl.md
# bird_motion_ctrl

Per-frame bird motion controller. It sits directly upstream of the flap-trajectory lookup. It turns player taps and frame ticks into the `bird_tap_time` index that the lookup consumes. It takes back the lookup's combinational `bird_go_up` offset and produces the registered screen row `bird_y` and the bird life-cycle state for the renderer and the game controller.

## Interface
Parameters:
- `Y_START`, 240: idle and restart screen row.
- `Y_TOP`, 0: ceiling row. `bird_y` never goes below this.
- `Y_FLOOR`, 400: ground row. Reaching it kills the bird.
- `TAP_SAT`, 127: saturation value of `bird_tap_time`.

Ports:
- `clk`, in, 1: system clock; the block has one clock.
- `rst_n`, in, 1: reset, asynchronous, active-low.
- `frame_tick`, in, 1: one-cycle pulse per video frame.
- `tap_btn`, in, 1: raw asynchronous flap button, active-high level.
- `game_start`, in, 1: one-cycle restart request from the game controller.
- `collide`, in, 1: pipe-collision flag, level.
- `bird_go_up`, in, 13 signed: trajectory offset, upward positive, combinational from `bird_tap_time`.
- `bird_tap_time`, out, 13: frames since the last accepted tap; 0 means idle.
- `bird_y`, out, 10: bird screen row, registered; down is positive.
- `bird_state`, out, 2: 0 IDLE, 1 FLY, 2 FALL, 3 DEAD.
- `ground_hit`, out, 1: one-cycle pulse on entry to DEAD.

## Operation
- **Tap input.** `tap_btn` passes through a 2-FF synchronizer. `tap_ev` is the rising edge of the synchronized level; one press produces exactly one `tap_ev`.
- **Internal register.** `base_y` (10 bit) holds the row latched at the last accepted tap.
- **Position arithmetic.** `y_calc = $signed({3'b0, base_y}) - bird_go_up`, 13-bit signed.
  - If `y_calc < Y_TOP`, the clamped value is `Y_TOP`.
  - If `y_calc >= Y_FLOOR`, the clamped value is `Y_FLOOR` and the floor is reached.
  - Otherwise the clamped value is `y_calc[9:0]`.
- **IDLE.**
  - `bird_tap_time` = 0 and `bird_y` = `Y_START`.
  - `frame_tick`, `collide` and `game_start` are ignored.
  - On `tap_ev`: `base_y` <= `bird_y`, `bird_tap_time` <= 1, go to FLY.
- **FLY.**
  - On `tap_ev`: `base_y` <= `bird_y` (the current registered value), `bird_tap_time` <= 1.
  - Otherwise, on `frame_tick`, `bird_tap_time` <= min(`bird_tap_time` + 1, `TAP_SAT`). At `TAP_SAT` it holds.
  - Every cycle, `bird_y` <= the clamped `y_calc`.
  - If the floor is reached: go to DEAD, `bird_y` = `Y_FLOOR`, pulse `ground_hit`.
  - Else if `collide` = 1: go to FALL.
- **FALL.**
  - Same as FLY except that `tap_ev` is ignored.
  - Reaching the floor: go to DEAD and pulse `ground_hit`.
- **DEAD.**
  - `bird_tap_time` and `bird_y` are frozen.
  - `game_start`: go to IDLE, `bird_tap_time` <= 0, `bird_y` <= `Y_START`, `base_y` <= `Y_START`.
- **Simultaneous events.**
  - `tap_ev` together with `frame_tick`: the tap wins and `bird_tap_time` = 1.
  - Floor reached together with `collide`: DEAD wins.
  - Floor reached together with `tap_ev` in FLY: DEAD wins and the tap is discarded.
- **Reset.** Asynchronous `rst_n` low at any time forces:
  - IDLE;
  - `bird_tap_time` = 0, `bird_y` = `Y_START`, `base_y` = `Y_START`;
  - `ground_hit` = 0 and both synchronizer flops = 0.

## Timing
- **Tap latency.** `tap_btn` rises before clk edge k. `bird_tap_time` = 1 is visible after edge k+2; this is the 3-cycle synchronizer and edge-detect latency.
- **Tick latency.** `frame_tick` high at edge n: the increment is visible after edge n.
- **Position latency.** `bird_go_up` is combinational from `bird_tap_time`. `bird_y` reflects a new `bird_tap_time` one cycle later.
- **Tap-cycle row.** In the cycle the tap is accepted, `bird_y` uses the old `base_y` and old `bird_go_up`. There is no jump: at `bird_tap_time` = 1, `bird_go_up` is small, so `bird_y` rises smoothly.
- **Ground pulse.** `ground_hit` is high for exactly the cycle after the transition into DEAD is registered, and it is a single cycle.
- **State output.** `bird_state` is registered with no output decode delay.

## Test plan
- **Reset values.** Pulse `rst_n` low mid-flight (`bird_tap_time` = 40) -> immediately `bird_state` = 0, `bird_tap_time` = 0, `bird_y` = 240, `ground_hit` = 0.
- **First tap.** From IDLE, raise `tap_btn` once -> `bird_tap_time` = 1 after 3 clocks, `bird_state` = 1. After 14 ticks `bird_tap_time` = 15 and `bird_y` = 200 (240 - 40).
- **Re-tap and tie-break.** Tap at `bird_tap_time` = 30 with `frame_tick` in the same cycle -> `bird_tap_time` = 1, `base_y` = the `bird_y` at that moment (not 240). Holding the button produces no second tap.
- **Saturation and ground.** No taps after the first -> `bird_tap_time` stops at 127. `bird_y` reaches 400, `bird_state` = 3, one `ground_hit` pulse, and `bird_y` is frozen.
- **Ceiling clamp.** Set `Y_START` = 20 and tap at 1-tick intervals -> `bird_y` never goes below 0 and the state stays FLY.
- **Collision then restart.** Assert `collide` at tick 10 -> state FALL and taps ignored, then DEAD at row 400. `game_start` -> IDLE, `bird_y` = 240, `bird_tap_time` = 0.
